// File: rtl/read_write_logic_and_dbbfr.sv
// Bus interface for an 8259-style controller. The CPU strobes are sampled
// once, and each write is committed when its write strobe rises. A small
// decode FSM steps through the ICW1..ICW4 initialisation sequence and then
// routes later writes into the OCW registers.
module read_write_logic_and_dbbfr (
    input  logic       clk,
    input  logic       rst,
    input  logic       CSn,
    input  logic       rdn,
    input  logic       wrn,
    input  logic       A0,
    input  logic [7:0] WR,
    input  logic [2:0] cadr,
    output logic       wrflg,
    output logic       rdflag,
    output logic       b0,
    output logic [7:0] icw1,
    output logic [7:0] icw2,
    output logic [7:0] icw3,
    output logic [7:0] icw4,
    output logic [7:0] ocw1,
    output logic [7:0] ocw2,
    output logic [7:0] ocw3,
    output logic       init_done
);

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    logic       r_csn, r_rdn, r_wrn, r_a0;
    logic [7:0] r_wr;
    logic [2:0] r_cadr;
    logic       r_pend_a0, r_armed;
    logic [7:0] r_pend_wr;
    logic       r_wrflg, r_rdflag, r_b0;
    state_t     r_state, w_state_nxt;
    logic [7:0] r_icw1, r_icw2, r_icw3, r_icw4, r_ocw1, r_ocw2, r_ocw3;
    logic [7:0] w_icw1, w_icw2, w_icw3, w_icw4, w_ocw1, w_ocw2, w_ocw3;
    logic       w_capture, w_commit;

    // A write is captured while the chip is selected and wrn is low. It
    // commits on the first sampled wrn high that still sees the chip selected.
    assign w_capture = !r_csn && !r_wrn;
    assign w_commit  = r_armed && !r_csn && r_wrn;

    // Sample every input once; strobes idle high after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csn  <= 1'b0;
            r_rdn  <= 1'b1;
            r_wrn  <= 1'b1;
            r_a0   <= 1'b0;
            r_wr   <= 8'h00;
            r_cadr <= 3'd0;
        end else begin
            r_csn  <= CSn;
            r_rdn  <= rdn;
            r_wrn  <= wrn;
            r_a0   <= A0;
            r_wr   <= WR;
            r_cadr <= cadr;
        end
    end

    // Hold the pending write. A deselect before the wrn rise disarms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_a0 <= 1'b0;
            r_pend_wr <= 8'h00;
            r_armed   <= 1'b0;
        end else if (w_capture) begin
            r_pend_a0 <= r_a0;
            r_pend_wr <= r_wr;
            r_armed   <= 1'b1;
        end else if (w_commit || r_csn) begin
            r_armed   <= 1'b0;
        end
    end

    // Registered status flags: write pulse, read-active, cascade match.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrflg  <= 1'b0;
            r_rdflag <= 1'b0;
            r_b0     <= 1'b0;
        end else begin
            r_wrflg  <= w_commit;
            r_rdflag <= !r_csn && !r_rdn && r_wrn;
            r_b0     <= (r_state == READY) && !r_icw1[1] && (r_cadr == r_icw3[2:0]);
        end
    end

    // Decode state and the programmed register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= UNINIT;
            r_icw1  <= 8'h00;
            r_icw2  <= 8'h00;
            r_icw3  <= 8'h00;
            r_icw4  <= 8'h00;
            r_ocw1  <= 8'h00;
            r_ocw2  <= 8'h00;
            r_ocw3  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_icw1  <= w_icw1;
            r_icw2  <= w_icw2;
            r_icw3  <= w_icw3;
            r_icw4  <= w_icw4;
            r_ocw1  <= w_ocw1;
            r_ocw2  <= w_ocw2;
            r_ocw3  <= w_ocw3;
        end
    end

    // Next-state and register decode for a committed write. ICW1 restarts the
    // sequence from any state; anything else depends on where we are.
    always_comb begin
        w_state_nxt = r_state;
        w_icw1 = r_icw1;
        w_icw2 = r_icw2;
        w_icw3 = r_icw3;
        w_icw4 = r_icw4;
        w_ocw1 = r_ocw1;
        w_ocw2 = r_ocw2;
        w_ocw3 = r_ocw3;
        if (w_commit) begin
            if (!r_pend_a0 && r_pend_wr[4]) begin
                w_icw1      = r_pend_wr;
                w_icw2      = 8'h00;
                w_icw3      = 8'h00;
                w_icw4      = 8'h00;
                w_ocw1      = 8'h00;
                w_ocw2      = 8'h00;
                w_ocw3      = 8'h02;
                w_state_nxt = WAIT_ICW2;
            end else begin
                case (r_state)
                    WAIT_ICW2: if (r_pend_a0) begin
                        w_icw2 = r_pend_wr;
                        if (!r_icw1[1])     w_state_nxt = WAIT_ICW3;
                        else if (r_icw1[0]) w_state_nxt = WAIT_ICW4;
                        else                w_state_nxt = READY;
                    end
                    WAIT_ICW3: if (r_pend_a0) begin
                        w_icw3      = r_pend_wr;
                        w_state_nxt = r_icw1[0] ? WAIT_ICW4 : READY;
                    end
                    WAIT_ICW4: if (r_pend_a0) begin
                        w_icw4      = r_pend_wr;
                        w_state_nxt = READY;
                    end
                    READY: begin
                        if (r_pend_a0)                    w_ocw1 = r_pend_wr;
                        else if (r_pend_wr[4:3] == 2'b00) w_ocw2 = r_pend_wr;
                        else if (r_pend_wr[4:3] == 2'b01) w_ocw3 = r_pend_wr;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wrflg     = r_wrflg;
    assign rdflag    = r_rdflag;
    assign b0        = r_b0;
    assign icw1      = r_icw1;
    assign icw2      = r_icw2;
    assign icw3      = r_icw3;
    assign icw4      = r_icw4;
    assign ocw1      = r_ocw1;
    assign ocw2      = r_ocw2;
    assign ocw3      = r_ocw3;
    assign init_done = (r_state == READY);

endmodule

// File: tb/tb_read_write_logic_and_dbbfr.sv
// Bench for read_write_logic_and_dbbfr. Each write that should commit pushes
// the expected register file onto a scoreboard; every wrflg pulse pops it.
module tb_read_write_logic_and_dbbfr;

    logic       clk = 1'b0;
    logic       rst, CSn, rdn, wrn, A0;
    logic [7:0] WR;
    logic [2:0] cadr;
    logic       wrflg, rdflag, b0, init_done;
    logic [7:0] icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;

    typedef struct packed {
        logic [7:0] icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
        logic       init_done;
    } snap_t;

    snap_t sb[$];
    snap_t m;
    snap_t mon_exp, mon_got;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    pulses  = 0;

    read_write_logic_and_dbbfr dut (
        .clk(clk), .rst(rst), .CSn(CSn), .rdn(rdn), .wrn(wrn), .A0(A0),
        .WR(WR), .cadr(cadr), .wrflg(wrflg), .rdflag(rdflag), .b0(b0),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
        .ocw1(ocw1), .ocw2(ocw2), .ocw3(ocw3), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Every wrflg-high cycle must match one queued expectation.
    always @(negedge clk) begin
        if (wrflg === 1'b1) begin
            pulses++;
            n_tests++;
            mon_got = {icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3, init_done};
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL wrflg_unexpected: pulse with no queued write, regs=%h", mon_got);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL commit_regs: got %h expected %h", mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; CSn = 1'b1; rdn = 1'b1; wrn = 1'b1; A0 = 1'b1;
        WR = 8'hAA; cadr = 3'd7;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m = '0;
        sb.delete();
    endtask

    task automatic do_write(input logic a0, input logic [7:0] d, input bit exp_commit);
        @(posedge clk); #1;
        CSn = 1'b0; A0 = a0; WR = d; wrn = 1'b0;
        if (exp_commit) sb.push_back(m);
        @(posedge clk); #1;
        wrn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected wrflg pulses never seen", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; CSn = 1'b1; rdn = 1'b1; wrn = 1'b1; A0 = 1'b1;
        WR = 8'hAA; cadr = 3'd7;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({wrflg, rdflag, b0, init_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {wrflg, rdflag, b0, init_done});
        end
        n_tests++;
        if ({icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3} !== 56'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h expected 0", {icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3});
        end
    endtask

    task automatic test_uninit_cancel();
        int p0;
        do_reset();
        // Non-ICW1 write in UNINIT still pulses but leaves registers alone.
        do_write(1'b1, 8'h55, 1'b1);
        check_drained("uninit_write_pulse");
        // Deselect before wrn rises: no commit.
        p0 = pulses;
        @(posedge clk); #1;
        CSn = 1'b0; A0 = 1'b0; WR = 8'h13; wrn = 1'b0;
        @(posedge clk); #1 CSn = 1'b1;
        @(posedge clk); #1 wrn = 1'b1;
        @(posedge clk); #1 CSn = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (pulses != p0 || init_done !== 1'b0 || icw1 !== 8'h00) begin
            n_fail++;
            $display("FAIL cancel_write: pulses %0d->%0d icw1=%h expected no pulse icw1=00", p0, pulses, icw1);
        end
        // Reset during the low phase discards the write.
        p0 = pulses;
        @(posedge clk); #1;
        CSn = 1'b0; A0 = 1'b0; WR = 8'h13; wrn = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; wrn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (pulses != p0 || icw1 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_discard: pulses %0d->%0d icw1=%h expected no pulse icw1=00", p0, pulses, icw1);
        end
    endtask

    task automatic test_icw_single();
        do_reset();
        m.icw1 = 8'h13; m.ocw3 = 8'h02;
        do_write(1'b0, 8'h13, 1'b1);
        m.icw2 = 8'h20;
        do_write(1'b1, 8'h20, 1'b1);
        m.icw4 = 8'h01; m.init_done = 1'b1;
        do_write(1'b1, 8'h01, 1'b1);
        check_drained("icw_single");
        @(negedge clk);
        n_tests++;
        if (init_done !== 1'b1 || icw3 !== 8'h00 || b0 !== 1'b0) begin
            n_fail++;
            $display("FAIL icw_single_final: init_done=%b icw3=%h b0=%b expected 1 00 0", init_done, icw3, b0);
        end
    endtask

    task automatic test_cascade_b0();
        // Re-initialise from READY; ICW1 clears the previous programming.
        m = '0;
        m.icw1 = 8'h10; m.ocw3 = 8'h02;
        do_write(1'b0, 8'h10, 1'b1);
        do_write(1'b0, 8'h08, 1'b1);   // A0=0, WR[4]=0 while waiting: ignored
        m.icw2 = 8'h08;
        do_write(1'b1, 8'h08, 1'b1);
        m.icw3 = 8'h04; m.init_done = 1'b1;
        do_write(1'b1, 8'h04, 1'b1);
        check_drained("cascade_init");
        @(posedge clk); #1 cadr = 3'd4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (b0 !== 1'b1) begin
            n_fail++;
            $display("FAIL b0_match: got %b expected 1", b0);
        end
        @(posedge clk); #1 cadr = 3'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (b0 !== 1'b0) begin
            n_fail++;
            $display("FAIL b0_mismatch: got %b expected 0", b0);
        end
    endtask

    task automatic test_ocw();
        m.ocw1 = 8'hFF;
        do_write(1'b1, 8'hFF, 1'b1);
        m.ocw2 = 8'h20;
        do_write(1'b0, 8'h20, 1'b1);
        m.ocw3 = 8'h0B;
        do_write(1'b0, 8'h0B, 1'b1);
        check_drained("ocw_writes");
    endtask

    task automatic test_read();
        logic [4:0] exp_rd;
        exp_rd = 5'b01110;
        @(posedge clk); #1;
        CSn = 1'b0; wrn = 1'b1; rdn = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k == 2) rdn = 1'b1;
            @(negedge clk);
            n_tests++;
            if (rdflag !== exp_rd[k]) begin
                n_fail++;
                $display("FAIL rdflag_seq[%0d]: got %b expected %b", k, rdflag, exp_rd[k]);
            end
        end
        // rdn and wrn low together: read suppressed, write still commits.
        @(posedge clk); #1;
        rdn = 1'b0; wrn = 1'b0; A0 = 1'b1; WR = 8'h5A;
        m.ocw1 = 8'h5A;
        sb.push_back(m);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (rdflag !== 1'b0) begin
                n_fail++;
                $display("FAIL rdflag_overlap[%0d]: got %b expected 0", k, rdflag);
            end
            @(posedge clk); #1;
        end
        rdn = 1'b1; wrn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_drained("read_write_overlap");
    endtask

    initial begin
        test_reset();
        test_uninit_cancel();
        test_icw_single();
        test_cascade_b0();
        test_ocw();
        test_read();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/read_write_logic_and_dbbfr.md
READ_WRITE_LOGIC_AND_DBBFR -- requirements
Module: read_write_logic_and_dbbfr

Interface
REQ-001 Parameters: none.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 CSn  input  1  chip select, active low.
REQ-006 rdn  input  1  read strobe, active low.
REQ-007 wrn  input  1  write strobe, active low.
REQ-008 A0  input  1  register address bit.
REQ-009 WR  input  8  CPU write data.
REQ-010 cadr  input  3  cascade address from bus.
REQ-011 wrflg  output  1  one-cycle pulse per committed write.
REQ-012 rdflag  output  1  read cycle active.
REQ-013 b0  output  1  cascade-address match flag.
REQ-014 icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3  output  8 each  programmed register contents.
REQ-015 init_done  output  1  high when decode FSM is in READY.

Function
REQ-016 All inputs are synchronous to clk; they are registered once (sampled), and the sampled copies drive all logic.
REQ-017 Write capture: in every cycle with sampled CSn=0 and wrn=0, A0 and WR are latched into a pending-write holding register.
REQ-018 Write commit: first cycle sampled wrn=1 after sampled wrn=0 with CSn=0, using the holding register; CSn deasserting before the wrn rise cancels it.
REQ-019 wrflg = 1 for exactly the one cycle after commit detection, else 0; back-to-back writes give separate pulses.
REQ-020 rdflag is registered: 1 when sampled CSn=0, rdn=0, wrn=1, else 0; rdn and wrn both low gives rdflag=0 and the write proceeds.
REQ-021 Decode FSM states: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
REQ-022 ICW1 = committed write with A0=0 and WR[4]=1, accepted in any state: load icw1, clear icw2..icw4 and ocw1, ocw2 to 0x00, ocw3 to 0x02; go WAIT_ICW2.
REQ-023 WAIT_ICW2, A0=1: load icw2; next WAIT_ICW3 if icw1[1]=0, else WAIT_ICW4 if icw1[0]=1, else READY.
REQ-024 WAIT_ICW3, A0=1: load icw3; next WAIT_ICW4 if icw1[0]=1, else READY.
REQ-025 WAIT_ICW4, A0=1: load icw4; next READY.
REQ-026 During WAIT_* states, writes with A0=0 and WR[4]=0 are ignored; state unchanged.
REQ-027 UNINIT: every write except ICW1 is ignored.
REQ-028 READY: A0=1 loads ocw1; A0=0, WR[4:3]=00 loads ocw2; A0=0, WR[4:3]=01 loads ocw3; all stay READY.
REQ-029 init_done = 1 exactly in READY.
REQ-030 b0 is registered: 1 when READY and icw1[1]=0 and cadr == icw3[2:0], else 0; re-evaluated every cycle.
REQ-031 Register outputs change only on commit cycles or reset.

Reset
REQ-032 rst=1 at a clock edge: FSM to UNINIT; all registers, outputs and sampled inputs to 0; sampled wrn and rdn to 1; pending write discarded.
REQ-033 Reset overrides a simultaneous commit; a write whose wrn rise comes after reset release without a post-reset low phase is not committed.

Verification
REQ-034 Reset, then CSn=1, rdn=wrn=A0=1, cadr=7, WR=0xAA held -> wrflg=rdflag=b0=0, init_done=0, all registers 0x00.
REQ-035 CSn=0: write A0=0 WR=0x13, then A0=1 WR=0x20, then A0=1 WR=0x01 -> three wrflg pulses; icw1=0x13, icw2=0x20, icw4=0x01, icw3=0x00; ocw3=0x02 after the ICW1 write; init_done=1.
REQ-036 Write 0x10, 0x08, 0x04 (A0=0,1,1) then cadr=4 -> icw3=0x04, READY, b0=1; cadr=3 -> b0=0.
REQ-037 In READY, write A0=1 0xFF, A0=0 0x20, A0=0 0x0B -> ocw1=0xFF, ocw2=0x20, ocw3=0x0B.
REQ-038 CSn=0, rdn=0, wrn=1 for 3 cycles -> rdflag=1 for 3 cycles, one cycle delayed; rdn=0 and wrn=0 -> rdflag=0.
REQ-039 Write in UNINIT with A0=1 WR=0x55 -> wrflg pulses, registers unchanged; CSn raised before wrn rise -> no wrflg.
